block_read_accumulator: RTL and testbench

//  Downstream consumer of the multiplier's block-read stream (EN_blockRead / VALID_memVal / memVal_data).
//  On request, pulses EN_blockRead, then sums sum_len streamed products into one wide accumulator.

---
 rtl/block_read_pkg.sv | 18 +
 rtl/block_read_accumulator_sat_accum.sv | 35 +++
 rtl/block_read_accumulator.sv | 155 +++++++++++++++
 tb/tb_block_read_accumulator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_read_pkg.sv
// Shared types and default sizing for the block-read accumulator.
package block_read_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 6;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int ACC_W     = 24;
  localparam int TIMEOUT   = 255;
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DONE
  } bra_state_t;

endpackage

// File: rtl/block_read_accumulator_sat_accum.sv
// Saturating unsigned accumulator: acc += din on add_en and pins at all-ones on overflow.
// Registered one-cycle update; clear takes priority over add, and sat stays set until clear.
module sat_accum #(
  parameter int ACC_W  = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  logic [ACC_W:0] sumWide;

  // One extra bit catches the carry that signals overflow.
  assign sumWide = {1'b0, acc} + (ACC_W+1)'(din);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (add_en) begin
      if (sumWide[ACC_W]) begin
        acc <= '1;
        sat <= 1'b1;
      end else begin
        acc <= sumWide[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/block_read_accumulator.sv
// Requests one product block, sums the streamed words into a saturating accumulator and
// presents the total with a valid/ack handshake; last word to VALID_sum is 1 clk.
module block_read_accumulator #(
  parameter int DATA_W  = block_read_pkg::DATA_W,
  parameter int ADDR_W  = block_read_pkg::ADDR_W,
  parameter int ACC_W   = block_read_pkg::ACC_W,
  parameter int TIMEOUT = block_read_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_sum,
  input  logic [ADDR_W:0]   sum_len,
  output logic              RDY_sum,
  output logic              EN_blockRead,
  input  logic              VALID_memVal,
  input  logic [DATA_W-1:0] memVal_data,
  output logic              VALID_sum,
  input  logic              ACK_sum,
  output logic [ACC_W-1:0]  sum_data,
  output logic [ADDR_W:0]   sum_count,
  output logic              ERR_timeout,
  output logic              ERR_sat
);
  import block_read_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  bra_state_t       state;
  bra_state_t       nextState;
  logic [ADDR_W:0]  lenQ;
  logic [ADDR_W:0]  countQ;
  logic [ADDR_W:0]  countInc;
  logic [ADDR_W:0]  lenClamped;
  logic [TMR_W-1:0] timerQ;

  logic startOp;
  logic acceptWord;
  logic idleTick;
  logic lastWord;
  logic timerExpire;

  logic clearAcc;
  logic rdyNext;
  logic blkNext;
  logic validNext;

  assign countInc    = countQ + 1'b1;
  assign lenClamped  = (sum_len > LEN_MAX) ? LEN_MAX : sum_len;
  assign startOp     = (state == IDLE) && EN_sum;
  assign acceptWord  = (state == COLLECT) && VALID_memVal;
  assign idleTick    = (state == COLLECT) && !VALID_memVal;
  assign lastWord    = acceptWord && (countInc == lenQ);
  // Expires on the idle cycle that brings the gap to TIMEOUT.
  assign timerExpire = idleTick && (timerQ == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (EN_sum) begin
          nextState = (sum_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        nextState = COLLECT;
      end
      COLLECT: begin
        if (lastWord || timerExpire) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (ACK_sum) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    clearAcc  = startOp;
    rdyNext   = (nextState == IDLE);
    blkNext   = (nextState == REQ);
    validNext = (nextState == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RDY_sum      <= 1'b1;
      EN_blockRead <= 1'b0;
      VALID_sum    <= 1'b0;
    end else begin
      RDY_sum      <= rdyNext;
      EN_blockRead <= blkNext;
      VALID_sum    <= validNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lenQ        <= '0;
      countQ      <= '0;
      timerQ      <= '0;
      ERR_timeout <= 1'b0;
    end else if (startOp) begin
      lenQ        <= lenClamped;
      countQ      <= '0;
      timerQ      <= '0;
      ERR_timeout <= 1'b0;
    end else if (acceptWord) begin
      countQ <= countInc;
      timerQ <= '0;
    end else if (idleTick) begin
      timerQ <= timerQ + 1'b1;
      if (timerExpire) begin
        ERR_timeout <= 1'b1;
      end
    end
  end

  assign sum_count = countQ;

  sat_accum #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (clearAcc),
    .add_en (acceptWord),
    .din    (memVal_data),
    .acc    (sum_data),
    .sat    (ERR_sat)
  );

  // Handshake invariants.
  assert property (@(posedge clk) disable iff (rst) EN_blockRead |=> !EN_blockRead);
  assert property (@(posedge clk) disable iff (rst) VALID_sum |-> !RDY_sum);
  assert property (@(posedge clk) disable iff (rst)
    (VALID_sum && !ACK_sum) |=> (VALID_sum && $stable(sum_data) && $stable(sum_count)));

endmodule

// File: tb/tb_block_read_accumulator.sv
// Bench for block_read_accumulator: directed table plus randomized ops against a schedule model.
module tb_block_read_accumulator;

  localparam int     ACC_WT  = 20;
  localparam longint SAT_MAX = (longint'(1) << ACC_WT) - 1;

  typedef struct {
    int     len;
    int     nWords;
    int     kind;
    int     val;
    int     gap;
    int     ackDelay;
    bit     enDuring;
    bit     enWithAck;
    longint eSum;
    int     eCnt;
    bit     eTo;
    bit     eSat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              EN_sum = 1'b0;
  logic [6:0]        sum_len = '0;
  logic              RDY_sum;
  logic              EN_blockRead;
  logic              VALID_memVal = 1'b0;
  logic [15:0]       memVal_data = '0;
  logic              VALID_sum;
  logic              ACK_sum = 1'b0;
  logic [ACC_WT-1:0] sum_data;
  logic [6:0]        sum_count;
  logic              ERR_timeout;
  logic              ERR_sat;

  int vecs = 0;
  int miscompares = 0;
  int blkCount = 0;
  int tickCnt;
  int doneAt;
  int words[0:127];
  int gaps[0:127];

  block_read_accumulator #(.ACC_W(ACC_WT)) dut (
    .clk          (clk),
    .rst          (rst),
    .EN_sum       (EN_sum),
    .sum_len      (sum_len),
    .RDY_sum      (RDY_sum),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .VALID_sum    (VALID_sum),
    .ACK_sum      (ACK_sum),
    .sum_data     (sum_data),
    .sum_count    (sum_count),
    .ERR_timeout  (ERR_timeout),
    .ERR_sat      (ERR_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && EN_blockRead) blkCount++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    tickCnt++;
    if (VALID_sum && doneAt < 0) doneAt = tickCnt;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " RDY_sum"}, RDY_sum, 1);
    chk({tag, " EN_blockRead"}, EN_blockRead, 0);
    chk({tag, " VALID_sum"}, VALID_sum, 0);
    chk({tag, " sum_data"}, sum_data, 0);
    chk({tag, " sum_count"}, sum_count, 0);
    chk({tag, " ERR_timeout"}, ERR_timeout, 0);
    chk({tag, " ERR_sat"}, ERR_sat, 0);
  endtask

  // Result of one op derived from the word/gap schedule with plain arithmetic.
  task automatic model(input int len, input int n, output longint s, output int c,
                       output bit to, output bit sat, output int tk);
    int     eff;
    longint total;
    bit     fin;
    eff = (len > 64) ? 64 : len;
    total = 0;
    fin = 0;
    c = 0;
    to = 0;
    tk = 0;
    if (eff != 0) begin
      for (int i = 0; i < n && !fin && !to; i++) begin
        if (gaps[i] >= 255) begin
          to = 1;
          tk += 255;
        end else begin
          tk += gaps[i] + 1;
          total += words[i];
          c++;
          if (c == eff) fin = 1;
        end
      end
      if (!fin && !to) begin
        to = 1;
        tk += 255;
      end
    end
    sat = (total > SAT_MAX);
    s = sat ? SAT_MAX : total;
  endtask

  task automatic fillWords(input int kind, input int val, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      words[i] = (kind == 0) ? (i + 1) * (9 - i) : val;
      gaps[i]  = gap;
    end
  endtask

  task automatic runOp(input string tag, input int len, input int n, input int ackDelay,
                       input bit enDuring, input bit enWithAck, input longint eSum,
                       input int eCnt, input bit eTo, input bit eSat);
    longint mS;
    int     mC;
    bit     mTo;
    bit     mSat;
    int     mTk;
    int     b0;
    int     w;
    model(len, n, mS, mC, mTo, mSat, mTk);
    b0 = blkCount;
    w = 0;
    while (!RDY_sum && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " ready"}, RDY_sum, 1);
    EN_sum = 1'b1;
    sum_len = 7'(len);
    tick();
    EN_sum = 1'b0;
    sum_len = 7'($urandom);
    tickCnt = 0;
    doneAt = -1;
    if (len == 0) begin
      if (VALID_sum) doneAt = 0;
    end else begin
      chk({tag, " blockRead pulse"}, EN_blockRead, 1);
      EN_sum = enDuring;
      tickCnt = -1;
      step();
      for (int i = 0; i < n; i++) begin
        repeat (gaps[i]) step();
        VALID_memVal = 1'b1;
        memVal_data = 16'(words[i]);
        step();
        VALID_memVal = 1'b0;
        memVal_data = 16'($urandom);
      end
      while (doneAt < 0 && tickCnt < 3000) step();
    end
    EN_sum = 1'b0;
    chk({tag, " valid latency"}, 64'(doneAt), 64'(mTk));
    chk({tag, " sum_data"}, sum_data, eSum);
    chk({tag, " sum_count"}, sum_count, eCnt);
    chk({tag, " ERR_timeout"}, ERR_timeout, eTo);
    chk({tag, " ERR_sat"}, ERR_sat, eSat);
    chk({tag, " RDY in done"}, RDY_sum, 0);
    repeat (ackDelay - 1) tick();
    chk({tag, " VALID held"}, VALID_sum, 1);
    chk({tag, " data held"}, sum_data, eSum);
    ACK_sum = 1'b1;
    EN_sum = enWithAck;
    sum_len = 7'd5;
    tick();
    ACK_sum = 1'b0;
    EN_sum = 1'b0;
    chk({tag, " VALID after ack"}, VALID_sum, 0);
    chk({tag, " RDY after ack"}, RDY_sum, 1);
    chk({tag, " data after ack"}, sum_data, eSum);
    if (enWithAck) begin
      tick();
      chk({tag, " EN with ack ignored"}, EN_blockRead, 0);
      chk({tag, " still idle"}, RDY_sum, 1);
    end
    chk({tag, " blockRead count"}, 64'(blkCount - b0), (len != 0) ? 64'd1 : 64'd0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{5, 5, 0, 0, 0, 1, 0, 0, 95, 5, 0, 0};
    tbl[1] = '{5, 5, 0, 0, 3, 4, 0, 1, 95, 5, 0, 0};
    tbl[2] = '{5, 3, 0, 0, 0, 2, 0, 0, 46, 3, 1, 0};
    tbl[3] = '{64, 64, 1, 65535, 0, 1, 0, 0, SAT_MAX, 64, 0, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{100, 70, 1, 1, 1, 1, 0, 0, 64, 64, 0, 0};
    tbl[6] = '{3, 5, 1, 7, 2, 3, 1, 1, 21, 3, 0, 0};

    repeat (3) tick();
    chkReset("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      fillWords(tbl[v].kind, tbl[v].val, tbl[v].nWords, tbl[v].gap);
      runOp($sformatf("vec%0d", v), tbl[v].len, tbl[v].nWords, tbl[v].ackDelay,
            tbl[v].enDuring, tbl[v].enWithAck, tbl[v].eSum, tbl[v].eCnt,
            tbl[v].eTo, tbl[v].eSat);
    end

    // Reset in the middle of a collect discards the partial sum.
    fillWords(0, 0, 5, 0);
    EN_sum = 1'b1;
    sum_len = 7'd5;
    tick();
    EN_sum = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      VALID_memVal = 1'b1;
      memVal_data = 16'(words[i]);
      tick();
    end
    VALID_memVal = 1'b0;
    rst = 1'b1;
    tick();
    chkReset("midrst");
    rst = 1'b0;
    runOp("post-rst", 5, 5, 1, 0, 0, 95, 5, 0, 0);

    for (int r = 0; r < 14; r++) begin
      int     len;
      int     eff;
      int     n;
      int     mode;
      longint mS;
      int     mC;
      bit     mTo;
      bit     mSat;
      int     mTk;
      len = $urandom_range(0, 70);
      eff = (len > 64) ? 64 : len;
      mode = $urandom_range(0, 3);
      n = (mode == 1) ? eff + 3 : (mode == 2) ? eff / 2 : eff;
      for (int i = 0; i < n; i++) begin
        words[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 255);
        gaps[i]  = $urandom_range(0, 3);
      end
      if (mode == 3 && n > 0) gaps[$urandom_range(0, n - 1)] = $urandom_range(252, 258);
      model(len, n, mS, mC, mTo, mSat, mTk);
      runOp($sformatf("rnd%0d", r), len, n, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), mS, mC, mTo, mSat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
